// File: rtl/dec_field_fmt.sv
// Decimal field formatter: converts an unsigned value to ASCII digits (LSB first)
// and streams them out right/left aligned with space or zero padding.
module dec_field_fmt #(
   parameter int DATA_W     = 32,
   parameter int MAX_DIGITS = 10,
   parameter int WIDTH_W    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_value,
   input  logic [WIDTH_W-1:0] in_width,
   input  logic               in_zero_pad,
   input  logic               in_left_align,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_char,
   output logic               out_last,
   output logic               busy,
   output logic [2:0]         dbg_state
);

   localparam int NW = $clog2(MAX_DIGITS + 1);
   localparam int CW = ((NW > WIDTH_W) ? NW : WIDTH_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CONVERT  = 3'd1,
      S_PAD_PRE  = 3'd2,
      S_DIGITS   = 3'd3,
      S_PAD_POST = 3'd4
   } state_t;

   // Stream handshake: a character transfers on a rising edge where out_valid
   // and out_ready are both high; out_valid/out_char/out_last stay put until then.
   // Requests transfer on an edge where in_valid and in_ready are both high.

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   v_q, v_d;
   logic [WIDTH_W-1:0]  width_q, width_d;
   logic                zero_q, zero_d;
   logic                left_q, left_d;
   logic [NW-1:0]       n_q, n_d;
   logic [NW-1:0]       dig_rem_q, dig_rem_d;
   logic [CW-1:0]       pad_rem_q, pad_rem_d;
   logic [3:0]          digit_q [MAX_DIGITS];
   logic [3:0]          digit_d [MAX_DIGITS];
   logic                out_valid_q, out_valid_d;
   logic [7:0]          out_char_q, out_char_d;
   logic                out_last_q, out_last_d;

   logic [DATA_W-1:0]   quot;
   logic [3:0]          cur_digit;
   logic [NW-1:0]       n_new;
   logic [CW-1:0]       width_ext;
   logic [CW-1:0]       n_ext;
   logic [CW-1:0]       pad_new;
   logic [7:0]          pad_char;
   logic [NW-1:0]       rd_idx;
   logic [7:0]          rd_char;
   logic                handshake;

   assign quot      = v_q / DATA_W'(10);
   assign cur_digit = 4'(v_q % DATA_W'(10));
   assign n_new     = n_q + NW'(1);
   assign width_ext = CW'(width_q);
   assign n_ext     = CW'(n_new);
   assign pad_new   = (width_ext > n_ext) ? (width_ext - n_ext) : '0;
   assign pad_char  = zero_q ? 8'h30 : 8'h20;
   assign rd_idx    = dig_rem_q - NW'(1);
   assign rd_char   = 8'h30 + {4'h0, digit_q[rd_idx]};
   assign handshake = out_valid_q && out_ready;

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      width_d     = width_q;
      zero_d      = zero_q;
      left_d      = left_q;
      n_d         = n_q;
      dig_rem_d   = dig_rem_q;
      pad_rem_d   = pad_rem_q;
      digit_d     = digit_q;
      out_valid_d = out_valid_q;
      out_char_d  = out_char_q;
      out_last_d  = out_last_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               v_d     = in_value;
               width_d = in_width;
               zero_d  = in_zero_pad;
               left_d  = in_left_align;
               n_d     = '0;
               state_d = S_CONVERT;
            end
         end

         S_CONVERT: begin
            digit_d[n_q] = cur_digit;
            v_d          = quot;
            n_d          = n_new;
            // The last digit produced is the MSB, so the first character is
            // loaded here to present out_valid right after the final divide.
            if (quot == '0) begin
               out_valid_d = 1'b1;
               pad_rem_d   = pad_new;
               if (!left_q && (pad_new != '0)) begin
                  state_d    = S_PAD_PRE;
                  out_char_d = pad_char;
                  pad_rem_d  = pad_new - CW'(1);
                  dig_rem_d  = n_new;
                  out_last_d = 1'b0;
               end else begin
                  state_d    = S_DIGITS;
                  out_char_d = 8'h30 + {4'h0, cur_digit};
                  dig_rem_d  = n_q;
                  out_last_d = (n_q == '0) && (pad_new == '0);
               end
            end
         end

         S_PAD_PRE, S_DIGITS, S_PAD_POST: begin
            if (handshake) begin
               if (out_last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else if (state_q == S_PAD_PRE) begin
                  if (pad_rem_q != '0) begin
                     out_char_d = pad_char;
                     pad_rem_d  = pad_rem_q - CW'(1);
                  end else begin
                     state_d    = S_DIGITS;
                     out_char_d = rd_char;
                     dig_rem_d  = rd_idx;
                     out_last_d = (rd_idx == '0);
                  end
               end else if ((state_q == S_DIGITS) && (dig_rem_q != '0)) begin
                  out_char_d = rd_char;
                  dig_rem_d  = rd_idx;
                  out_last_d = (rd_idx == '0) && (pad_rem_q == '0);
               end else begin
                  // Trailing pad of a left-aligned field is always spaces.
                  state_d    = S_PAD_POST;
                  out_char_d = 8'h20;
                  pad_rem_d  = pad_rem_q - CW'(1);
                  out_last_d = (pad_rem_q == CW'(1));
               end
            end
         end

         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         v_q         <= '0;
         width_q     <= '0;
         zero_q      <= 1'b0;
         left_q      <= 1'b0;
         n_q         <= '0;
         dig_rem_q   <= '0;
         pad_rem_q   <= '0;
         digit_q     <= '{default: '0};
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         width_q     <= width_d;
         zero_q      <= zero_d;
         left_q      <= left_d;
         n_q         <= n_d;
         dig_rem_q   <= dig_rem_d;
         pad_rem_q   <= pad_rem_d;
         digit_q     <= digit_d;
         out_valid_q <= out_valid_d;
         out_char_q  <= out_char_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_dec_field_fmt.sv
// Bench for dec_field_fmt: directed and random fields checked against a printf-style
// reference that builds the expected character string from the value and descriptor.
module tb_dec_field_fmt;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [4:0]  in_width;
   logic        in_zero_pad;
   logic        in_left_align;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_char;
   logic        out_last;
   logic        busy;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_c[$];
   bit         got_l[$];
   int         exp_lat;
   int         lat;
   int         hold_err;
   int         early_rdy;
   bit         timeout_f;
   logic       rdy_after;
   logic       busy_after;
   logic       valid_after;

   dec_field_fmt dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_value     (in_value),
      .in_width     (in_width),
      .in_zero_pad  (in_zero_pad),
      .in_left_align(in_left_align),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_char     (out_char),
      .out_last     (out_last),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   task automatic build_exp(input logic [31:0] v, input int w, input bit z, input bit l);
      string s;
      int    pad;
      s = $sformatf("%0d", v);
      pad = (w > s.len()) ? (w - s.len()) : 0;
      exp_q.delete();
      if (!l) repeat (pad) exp_q.push_back(z ? 8'h30 : 8'h20);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
      if (l) repeat (pad) exp_q.push_back(8'h20);
      exp_lat = s.len();
   endtask

   // ---------------- driver ----------------
   // Called and returns at a negedge. mode: 0 ready always, 1 toggling, 2 random.
   task automatic run_field(input logic [31:0] v, input logic [4:0] w, input bit z,
                            input bit l, input int mode);
      int         cyc;
      int         k;
      bit         stalled;
      bit         done;
      logic [7:0] pc;
      logic       pl;
      got_c.delete();
      got_l.delete();
      lat = -1; hold_err = 0; early_rdy = 0; timeout_f = 0;
      k = 0;
      while (in_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b1; in_value = v; in_width = w; in_zero_pad = z; in_left_align = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_value = $urandom; in_width = 5'($urandom);
      in_zero_pad = 1'($urandom); in_left_align = 1'($urandom);
      cyc = 0; stalled = 0; done = 0; pc = 8'h00; pl = 1'b0;
      while (!done && cyc < 400) begin
         if (stalled && (out_valid !== 1'b1 || out_char !== pc || out_last !== pl)) hold_err++;
         if (out_valid === 1'b1 && lat < 0) lat = cyc;
         if (in_ready === 1'b1) early_rdy++;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid === 1'b1 && out_ready) begin
            got_c.push_back(out_char);
            got_l.push_back(out_last);
            if (out_last === 1'b1) done = 1;
         end
         stalled = (out_valid === 1'b1) && !out_ready;
         pc = out_char;
         pl = out_last;
         @(negedge clk);
         cyc++;
      end
      timeout_f   = !done;
      rdy_after   = in_ready;
      busy_after  = busy;
      valid_after = out_valid;
      out_ready   = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_value = '0; in_width = '0;
      in_zero_pad = 1'b0; in_left_align = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: valid=%b last=%b busy=%b required 0 0 0", out_valid, out_last, busy);
      end
      total++;
      if (out_char !== 8'h00) begin
         bad++;
         $display("FAIL reset_char: got=%h required=00", out_char);
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_ready_in_rst: got=%b required=0", in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready_after: got=%b required=1", in_ready);
      end
   endtask

   task automatic test_directed;
      logic [31:0] tv [7] = '{32'd5, 32'd5, 32'd5, 32'd123456, 32'd0, 32'd4294967295, 32'd42};
      logic [4:0]  tw [7] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd12, 5'd3};
      bit          tz [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      bit          tl [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int t = 0; t < 7; t++) begin
         build_exp(tv[t], int'(tw[t]), tz[t], tl[t]);
         run_field(tv[t], tw[t], tz[t], tl[t], 0);
         total++;
         if (timeout_f || got_c.size() != exp_q.size()) begin
            bad++;
            $display("FAIL directed[%0d]_len: got=%0d required=%0d timeout=%0b", t, got_c.size(), exp_q.size(), timeout_f);
         end
         for (int i = 0; i < got_c.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_c[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
               bad++;
               $display("FAIL directed[%0d]_char%0d: got=%h last=%b required=%h last=%b", t, i, got_c[i], got_l[i], exp_q[i], (i == exp_q.size() - 1));
            end
         end
         total++;
         if (lat != exp_lat) begin
            bad++;
            $display("FAIL directed[%0d]_latency: got=%0d required=%0d", t, lat, exp_lat);
         end
         total++;
         if (rdy_after !== 1'b1 || busy_after !== 1'b0 || valid_after !== 1'b0 || early_rdy != 0) begin
            bad++;
            $display("FAIL directed[%0d]_idle: in_ready=%b busy=%b valid=%b early=%0d required 1 0 0 0", t, rdy_after, busy_after, valid_after, early_rdy);
         end
      end
   endtask

   task automatic test_stall;
      build_exp(32'd42, 5, 1'b0, 1'b0);
      run_field(32'd42, 5'd5, 1'b0, 1'b0, 1);
      total++;
      if (timeout_f || got_c.size() != exp_q.size()) begin
         bad++;
         $display("FAIL stall_len: got=%0d required=%0d", got_c.size(), exp_q.size());
      end
      for (int i = 0; i < got_c.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_c[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
            bad++;
            $display("FAIL stall_char%0d: got=%h last=%b required=%h", i, got_c[i], got_l[i], exp_q[i]);
         end
      end
      total++;
      if (hold_err != 0) begin
         bad++;
         $display("FAIL stall_hold: got=%0d unstable cycles required=0", hold_err);
      end
      total++;
      if (early_rdy != 0 || rdy_after !== 1'b1) begin
         bad++;
         $display("FAIL stall_in_ready: early=%0d after=%b required 0 1", early_rdy, rdy_after);
      end
   endtask

   task automatic test_back_to_back;
      for (int t = 0; t < 3; t++) begin
         logic [31:0] v;
         v = 32'd907 * (t + 1);
         build_exp(v, 6, t[0], 1'b0);
         run_field(v, 5'd6, t[0], 1'b0, 0);
         total++;
         if (got_c != exp_q || rdy_after !== 1'b1) begin
            bad++;
            $display("FAIL b2b[%0d]: got_len=%0d required_len=%0d in_ready_after=%b", t, got_c.size(), exp_q.size(), rdy_after);
         end
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 40; t++) begin
         logic [31:0] v;
         logic [4:0]  w;
         bit          z;
         bit          l;
         int          errs;
         v = $urandom >> $urandom_range(0, 31);
         w = 5'($urandom_range(0, 31));
         z = 1'($urandom);
         l = 1'($urandom);
         build_exp(v, int'(w), z, l);
         run_field(v, w, z, l, 2);
         errs = 0;
         if (got_c.size() != exp_q.size() || timeout_f) errs++;
         for (int i = 0; i < got_c.size() && i < exp_q.size(); i++)
            if (got_c[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) errs++;
         if (lat != exp_lat || hold_err != 0 || early_rdy != 0 || rdy_after !== 1'b1) errs++;
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL random[%0d] v=%0d w=%0d z=%0b l=%0b: got_len=%0d required_len=%0d lat=%0d required_lat=%0d hold=%0d errs=%0d",
                     t, v, w, z, l, got_c.size(), exp_q.size(), lat, exp_lat, hold_err, errs);
         end
      end
   endtask

   task automatic test_rst_mid;
      int k;
      int stray;
      out_ready = 1'b1;
      in_valid = 1'b1; in_value = 32'd12345; in_width = 5'd0;
      in_zero_pad = 1'b0; in_left_align = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (out_valid !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre: valid=%b busy=%b required 1 1", out_valid, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_abort: valid=%b busy=%b in_ready=%b required 0 0 0", out_valid, busy, in_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_in_ready: got=%b required=1", in_ready);
      end
      stray = 0;
      repeat (4) begin
         if (out_valid !== 1'b0) stray++;
         @(negedge clk);
      end
      total++;
      if (stray != 0) begin
         bad++;
         $display("FAIL rst_mid_stray: got=%0d stray valid cycles required=0", stray);
      end
      build_exp(32'd7, 0, 1'b0, 1'b0);
      run_field(32'd7, 5'd0, 1'b0, 1'b0, 0);
      total++;
      if (got_c != exp_q || got_l.size() != 1 || got_l[0] !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_restart: got_len=%0d required_len=1 first=%h required=37", got_c.size(), (got_c.size() > 0) ? got_c[0] : 8'h00);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_back_to_back();
      test_random();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
